axi4_lite_master: RTL
=====================

Name: axi4_lite_master

Overview:
- AXI4-Lite initiator that drives the five AXI4-Lite channels toward an AXI4-Lite slave in the same subsystem.
- Converts single-beat commands from a simple local valid/ready command port into AXI4-Lite write or read transactions.
- Returns the slave's response (BRESP/RRESP, RDATA) on a local response port.
- Handles one outstanding transaction at a time.

Parameters:
ADDR_WIDTH, 32, width of AWADDR/ARADDR and cmd_addr
DATA_WIDTH, 32, width of WDATA/RDATA, cmd_wdata, rsp_rdata; legal values 32 or 64
STRB_WIDTH, DATA_WIDTH/8, width of WSTRB and cmd_wstrb (derived, do not override)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  synchronous active-low reset
cmd_valid  in  1  local command valid
cmd_ready  out  1  local command accept; high only in IDLE
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  transaction address, passed unchanged to AWADDR/ARADDR
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  STRB_WIDTH  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_write  out  1  response belongs to a write
rsp_resp  out  2  captured BRESP or RRESP
rsp_rdata  out  DATA_WIDTH  captured RDATA; 0 for writes
AWADDR  out  ADDR_WIDTH  write address
AWVALID  out  1  write address valid
AWREADY  in  1  write address ready
WDATA  out  DATA_WIDTH  write data
WSTRB  out  STRB_WIDTH  write strobes
WVALID  out  1  write data valid
WREADY  in  1  write data ready
BRESP  in  2  write response
BVALID  in  1  write response valid
BREADY  out  1  write response ready
ARADDR  out  ADDR_WIDTH  read address
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
RDATA  in  DATA_WIDTH  read data
RRESP  in  2  read response
RVALID  in  1  read data valid
RREADY  out  1  read data ready

Behaviour:
- Reset (ARESETn low at a rising edge): state=IDLE. All outputs 0 (AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write, rsp_resp, rsp_rdata, AWADDR, WDATA, WSTRB, ARADDR) except cmd_ready.
  - cmd_ready is combinational (state==IDLE && ARESETn), so it is 0 during reset.
- Reset mid-transaction: abandon the transaction; all VALID/READY outputs low on the next edge; any pending slave response is not consumed.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - On cmd_valid && cmd_ready, register addr/wdata/wstrb onto the AXI outputs.
  - Write: go to WR_REQ with AWVALID=1 and WVALID=1 on the next cycle (1-cycle latency from accept).
  - Read: go to RD_REQ with ARVALID=1 on the next cycle.
- WR_REQ:
  - AW and W complete independently. Each VALID clears on the edge where VALID && READY is sampled. The other VALID stays high, with address/data stable, until its own handshake.
  - When both have handshaked (same cycle or different cycles), go to WR_RESP.
  - BREADY is never asserted before both handshakes complete.
- WR_RESP: BREADY=1. On BVALID && BREADY: capture BRESP, set rsp_write=1, rsp_rdata=0, BREADY=0, go to RSP.
- RD_REQ: ARVALID held until ARREADY sampled high; then ARVALID=0, go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID && RREADY: capture RDATA/RRESP, set rsp_write=0, RREADY=0, go to RSP.
- RSP:
  - rsp_valid=1; rsp_* held stable until rsp_valid && rsp_ready.
  - Then rsp_valid=0 and go to IDLE; cmd_ready rises the cycle after the response handshake.
- AXI rules:
  - No VALID depends combinationally on any READY.
  - Once asserted, a VALID is never dropped before its handshake, except on reset.
  - BREADY/RREADY are asserted only in their response states.
- Protocol tolerance:
  - A slave that asserts AWREADY/WREADY/ARREADY before VALID causes no effect until VALID is high.
  - BVALID/RVALID arriving in the same cycle as the entry into WR_RESP/RD_RESP is accepted on the following edge. BREADY/RREADY are registered and high from state entry.
- Response codes (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11) are passed through unmodified; no retry.
- Back-to-back: minimum 1 idle cycle between response handshake and next command accept.

Test Plan:
1. Write 0x00000004/0xDEADBEEF/WSTRB 4'hF against a responsive slave -> AWVALID=WVALID=1 one cycle after accept; BREADY only after both handshakes; rsp_valid with rsp_write=1, rsp_resp=00.
2. Read 0x00000004 after test 1 -> ARVALID one cycle after accept; rsp_rdata=0xDEADBEEF, rsp_resp=00, rsp_write=0.
3. Slave asserts WREADY 2 cycles before AWREADY -> WVALID drops after its handshake; AWVALID and AWADDR held stable; BREADY rises only after AW handshake.
4. RVALID returned while rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, no new ARVALID; response completes when rsp_ready=1.
5. Slave returns BRESP=2'b10 for write to 0x00000010 -> rsp_resp=10; next read to 0x00000004 proceeds normally.
6. ARESETn driven low for one cycle while AWVALID=1 and WVALID=1 -> all VALID/READY and rsp_valid low on next edge; cmd_ready=1 after reset release.

Source files
------------

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: turns one local command at a time into an AXI4-Lite write or read
// and returns the captured slave response on a local valid/ready response port.
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [1:0]            rsp_resp,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [STRB_WIDTH-1:0] WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY,
  output logic [2:0]            dbg_state_o
);

  // Handshake rule on every channel: a transfer happens on the rising edge where VALID and
  // READY are both high; VALID never waits on READY and is held until that edge.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  aw_left, w_left;

  assign cmd_ready   = (state_q == S_IDLE) && ARESETn;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign AWADDR      = awaddr_q;
  assign AWVALID     = awvalid_q;
  assign WDATA       = wdata_q;
  assign WSTRB       = wstrb_q;
  assign WVALID      = wvalid_q;
  assign BREADY      = bready_q;
  assign ARADDR      = araddr_q;
  assign ARVALID     = arvalid_q;
  assign RREADY      = rready_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_left     = awvalid_q && !AWREADY;
    w_left      = wvalid_q && !WREADY;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; BREADY only once neither is outstanding.
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_resp_d  = BRESP;
          rsp_rdata_d = '0;
          state_d     = S_RSP;
        end
      end
      S_RD_REQ: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_resp_d  = RRESP;
          rsp_rdata_d = RDATA;
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= 2'b00;
      rsp_rdata_q <= '0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
    end
  end

endmodule
